segment_scan_decoder: RTL



---
 rtl/segment_scan_decoder.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/segment_scan_decoder.sv
// Snoops a multiplexed active-low 7-segment bus and rebuilds the hex digit shown at each position.
// Optional per-digit refresh timeout is compiled in when SEGMENT_SCAN_TIMEOUT_EN is defined.
module segment_scan_decoder #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4,
  parameter int TIMEOUT       = 1000000
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [DIGITS-1:0]   i_an,
  input  logic [6:0]          i_seg,
  input  logic                i_err_clr,
  output logic [4*DIGITS-1:0] o_val,
  output logic [DIGITS-1:0]   o_vld,
  output logic [DIGITS-1:0]   o_err,
  output logic                o_upd
);
  localparam int SW = DIGITS + 7;
  localparam int CW = $clog2(STABLE_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  logic [SW-1:0]     sync1_reg, sync2_reg, prev_reg;
  state_t            state_reg;
  logic [CW-1:0]     cnt_reg;
  logic              upd_reg;

  logic [DIGITS-1:0] s_an;
  logic [6:0]        s_seg;
  logic              same, single, cap_fire;
  logic              dec_ok, dec_blank;
  logic [3:0]        dec_val;
  logic [DIGITS-1:0] tmo_hit;

  assign s_an     = sync2_reg[SW-1:7];
  assign s_seg    = sync2_reg[6:0];
  assign same     = (sync2_reg == prev_reg);
  assign cap_fire = (state_reg == SETTLE) && same && (cnt_reg == CW'(STABLE_CYCLES));

  always_comb begin
    int lows;
    lows = 0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!s_an[i]) lows++;
    end
    single = (lows == 1);
  end

  always_comb begin
    dec_ok    = 1'b1;
    dec_blank = 1'b0;
    dec_val   = 4'h0;
    case (s_seg)
      7'h40: dec_val = 4'h0;
      7'h79: dec_val = 4'h1;
      7'h24: dec_val = 4'h2;
      7'h30: dec_val = 4'h3;
      7'h19: dec_val = 4'h4;
      7'h12: dec_val = 4'h5;
      7'h02: dec_val = 4'h6;
      7'h78: dec_val = 4'h7;
      7'h00: dec_val = 4'h8;
      7'h10: dec_val = 4'h9;
      7'h08: dec_val = 4'hA;
      7'h03: dec_val = 4'hB;
      7'h46: dec_val = 4'hC;
      7'h21: dec_val = 4'hD;
      7'h06: dec_val = 4'hE;
      7'h0E: dec_val = 4'hF;
      7'h7F: begin
        dec_ok    = 1'b0;
        dec_blank = 1'b1;
      end
      default: dec_ok = 1'b0;
    endcase
  end

  // Synchronizer idles at all-ones (bus dark) so a reset never looks like a lit digit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_reg <= '1;
      sync2_reg <= '1;
      prev_reg  <= '1;
      state_reg <= IDLE;
      cnt_reg   <= '0;
      upd_reg   <= 1'b0;
    end else begin
      sync1_reg <= {i_an, i_seg};
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
      upd_reg   <= cap_fire | (|tmo_hit);
      case (state_reg)
        IDLE: begin
          if (single) begin
            state_reg <= SETTLE;
            cnt_reg   <= CW'(1);
          end
        end
        SETTLE: begin
          if (!same) begin
            cnt_reg <= CW'(1);
            if (!single) state_reg <= IDLE;
          end else if (cap_fire) begin
            state_reg <= HOLD;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        HOLD: begin
          if (!same) begin
            cnt_reg   <= CW'(1);
            state_reg <= single ? SETTLE : IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign o_upd = upd_reg;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic       hit;
      logic [3:0] val_reg;
      logic       vld_reg, err_reg;

      assign hit = cap_fire && !s_an[gi];

      // A new error on this digit wins over a simultaneous clear request.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          val_reg <= 4'h0;
          vld_reg <= 1'b0;
          err_reg <= 1'b0;
        end else begin
          if (hit) begin
            vld_reg <= dec_ok;
            if (dec_ok) val_reg <= dec_val;
          end else if (tmo_hit[gi]) begin
            vld_reg <= 1'b0;
          end
          err_reg <= (hit && !dec_ok && !dec_blank) || (err_reg && !i_err_clr);
        end
      end

`ifdef SEGMENT_SCAN_TIMEOUT_EN
      localparam int TW = $clog2(TIMEOUT + 1);
      logic [TW-1:0] tmo_reg;

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          tmo_reg <= '0;
        end else if (hit) begin
          tmo_reg <= '0;
        end else if (tmo_reg != TW'(TIMEOUT)) begin
          tmo_reg <= tmo_reg + 1'b1;
        end
      end

      assign tmo_hit[gi] = !hit && (tmo_reg == TW'(TIMEOUT - 1));
`else
      // Without refresh counters a digit stays valid until recaptured; TIMEOUT has no effect.
      assign tmo_hit[gi] = (TIMEOUT < 0);
`endif

      assign o_val[4*gi +: 4] = val_reg;
      assign o_vld[gi]        = vld_reg;
      assign o_err[gi]        = err_reg;
    end
  endgenerate
endmodule
